// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the Op_ID codes (also used by ALU-control decode) and FSM states.
package muldiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// md_step: one radix-2 step of shift-add multiply or restoring divide.
// Ports: i_acc/i_operand/i_div in; o_acc (next acc), o_qbit (quotient bit) out.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_qbit
);
    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_msum;
    logic [WIDTH:0] w_rsh;
    logic [WIDTH:0] w_diff;
    logic           w_q;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        w_add  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
        w_msum = i_acc[0] ? w_add : {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        // Divide: acc = {remainder, dividend bits / quotient bits}.
        w_rsh  = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_rsh - {1'b0, i_operand};
        w_q    = ~w_diff[WIDTH];
        o_acc  = {w_msum, i_acc[WIDTH-1:1]};
        o_qbit = 1'b0;
        if (i_div) begin
            // The quotient bit slot is left clear; the caller inserts o_qbit.
            o_acc  = {(w_q ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                      i_acc[WIDTH-2:0], 1'b0};
            o_qbit = w_q;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one bit per cycle.
// Ports: clk/reset/flush, Start_ID/Op_ID/SrcA_ID/SrcB_ID, MtHi_ID/MtLo_ID,
// RdHiLo_ID in; Hi_EX/Lo_EX, MdBusy_EX/MdDone_EX/MdStall_EX out.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             Start_ID,
    input  logic [1:0]       Op_ID,
    input  logic [WIDTH-1:0] SrcA_ID,
    input  logic [WIDTH-1:0] SrcB_ID,
    input  logic             MtHi_ID,
    input  logic             MtLo_ID,
    input  logic             RdHiLo_ID,
    output logic [WIDTH-1:0] Hi_EX,
    output logic [WIDTH-1:0] Lo_EX,
    output logic             MdBusy_EX,
    output logic             MdDone_EX,
    output logic             MdStall_EX
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          r_state;
    md_state_e          w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_divz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_start;
    logic               w_done;
    logic               w_mt_ok;
    logic               w_sgn;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_b),
        .i_div     (r_div),
        .o_acc     (w_step_acc),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (Start_ID && !flush) begin
                    w_next  = ST_RUN;
                    w_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush)
                    w_next = ST_IDLE;
                else if (r_cnt == CW'(1))
                    w_next = ST_FIX;
            end
            ST_FIX: begin
                w_next = ST_IDLE;
                w_done = ~flush;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mt_ok = (r_state == ST_IDLE) && !flush;
        w_sgn   = md_is_signed(Op_ID);
        w_a_neg = w_sgn & SrcA_ID[WIDTH-1];
        w_b_neg = w_sgn & SrcB_ID[WIDTH-1];
        w_a_mag = w_a_neg ? -SrcA_ID : SrcA_ID;
        w_b_mag = w_b_neg ? -SrcB_ID : SrcB_ID;
        // Sign fix-up on magnitude results.
        w_prod  = r_neg_q ? -r_acc : r_acc;
        w_quo   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem   = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        // Divide by zero reports all ones regardless of sign.
        if (r_divz)
            w_quo = '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_mt_ok && MtHi_ID)
                r_hi <= SrcA_ID;
            if (w_mt_ok && MtLo_ID)
                r_lo <= SrcA_ID;
            if (w_start) begin
                r_cnt   <= CW'(WIDTH);
                r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                r_b     <= w_b_mag;
                r_div   <= md_is_div(Op_ID);
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_divz  <= md_is_div(Op_ID) && (SrcB_ID == '0);
            end else if (r_state == ST_RUN && !flush) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
            end
            if (w_done) begin
                if (r_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end
        end
    end

    assign Hi_EX      = r_hi;
    assign Lo_EX      = r_lo;
    assign MdBusy_EX  = (r_state != ST_IDLE);
    assign MdDone_EX  = w_done & ~reset;
    assign MdStall_EX = MdBusy_EX & (RdHiLo_ID | Start_ID | MtHi_ID | MtLo_ID);

endmodule
